// File: rtl/serial_word_receiver_if.sv
// Serial receiver bus bundle.
// Groups the serial input side (ser_in, ser_valid, frame_start), the output
// handshake (out_word, out_valid, out_ready) and the status/error signals
// (busy, overrun, frame_err, parity_err, clear_err).
//   master : the environment (drives serial bits, consumes words)
//   slave  : the receiver
interface serial_word_receiver_if #(
  parameter int unsigned WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic             out_ready;
  logic             clear_err;
  logic [WIDTH-1:0] out_word;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             frame_err;
  logic             parity_err;

  modport master (
    output ser_in, ser_valid, frame_start, out_ready, clear_err,
    input  out_word, out_valid, busy, overrun, frame_err, parity_err
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, out_ready, clear_err,
    output out_word, out_valid, busy, overrun, frame_err, parity_err
  );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver, LSB-first framed words.
// Reassembles WIDTH-bit frames, buffers one finished word behind a
// valid/ready handshake, and reports sticky overrun/framing/parity errors.
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous active-high reset
//   bus   : serial_word_receiver_if.slave (serial input, output handshake,
//           status flags, clear_err)
// Optional build macro PARITY_CHECK_EN: adds a trailing even-parity bit per
// frame and drives parity_err; without it parity_err is tied 0.
module serial_word_receiver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_word_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PARITY_CHECK_EN
    ,PARITY = 2'd2
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             ferr_q, ferr_d;

  logic [WIDTH-1:0] shift_val;
  logic [WIDTH-1:0] word_val;
  logic             word_done;
  logic             abort_set;
  logic             buf_free;

`ifdef PARITY_CHECK_EN
  logic perr_q, perr_d;
  logic par_set;
`endif

  assign shift_val = {bus.ser_in, shreg_q[WIDTH-1:1]};
  // The buffer can accept a word if empty or being drained this very cycle.
  assign buf_free  = ~vld_q | bus.out_ready;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    word_val  = shift_val;
    abort_set = 1'b0;
`ifdef PARITY_CHECK_EN
    par_set   = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.ser_valid && bus.frame_start) begin
          shreg_d = shift_val;
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_valid) begin
          shreg_d = shift_val;
          if (bus.frame_start) begin
            abort_set = 1'b1;
            cnt_d     = CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
              state_d = PARITY;
`else
              state_d   = IDLE;
              word_done = 1'b1;
`endif
            end
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.ser_valid) begin
          if (bus.frame_start) begin
            // Early frame_start on the parity slot restarts a frame.
            abort_set = 1'b1;
            shreg_d   = shift_val;
            cnt_d     = CNT_W'(1);
            state_d   = SHIFT;
          end else begin
            state_d = IDLE;
            if (^{shreg_q, bus.ser_in} == 1'b0) begin
              word_done = 1'b1;
              word_val  = shreg_q;
            end else begin
              par_set = 1'b1;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Output buffer: drain on transfer, reload (possibly same cycle) on
    // completion, drop and flag overrun when still full.
    out_d = out_q;
    vld_d = vld_q & ~bus.out_ready;
    if (word_done && buf_free) begin
      out_d = word_val;
      vld_d = 1'b1;
    end

    // Set events win over clear_err in the same cycle.
    ovr_d  = (word_done & ~buf_free) | (ovr_q & ~bus.clear_err);
    ferr_d = abort_set | (ferr_q & ~bus.clear_err);
`ifdef PARITY_CHECK_EN
    perr_d = par_set | (perr_q & ~bus.clear_err);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.out_word  = out_q;
  assign bus.out_valid = vld_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
Serial-to-parallel receiver. It is the far end of the 4-bit universal register's shift-right serial output, which presents Q_series = q0 first, so data arrives LSB-first.
- Reassembles framed serial bits into WIDTH-bit words.
- Buffers one completed word in an output register with a valid/ready handshake, so the next frame can be received while the consumer stalls.
- Reports overrun and framing errors as sticky flags.

Parameters:
WIDTH, 4, data bits per frame; legal range 2..32.
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  single clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
ser_in  input  1  serial data bit, sampled only when ser_valid=1.
ser_valid  input  1  ser_in carries a bit this cycle.
frame_start  input  1  qualifies the current ser_valid bit as bit 0 of a new frame.
out_ready  input  1  consumer accepts out_word this cycle.
clear_err  input  1  clears overrun, frame_err and parity_err.
out_word  output  WIDTH  received word; bit 0 is the first bit received.
out_valid  output  1  out_word holds an unconsumed word.
busy  output  1  a frame is partially received (state SHIFT or PARITY).
overrun  output  1  sticky: a completed word was dropped because the buffer was full.
frame_err  output  1  sticky: a frame was aborted by an early frame_start.
parity_err  output  1  sticky: parity mismatch (only with PARITY_CHECK_EN; otherwise tied 0).

Behaviour:
- Reset, synchronous when reset=1 at posedge: all outputs, the shift register, the bit counter and the state go to 0/IDLE. Reset overrides every other input in the same cycle and mid-frame; a partial frame is discarded without setting any flag.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - ser_valid=1 and frame_start=1: shift in ser_in, cnt=1, go to SHIFT.
  - ser_valid=1 and frame_start=0: bit ignored, no flag.
- Shift rule: on each accepted bit, shreg <= {ser_in, shreg[WIDTH-1:1]} (shift right, new bit enters at the MSB). After WIDTH accepted bits, the first bit sits in bit 0.
- SHIFT, ser_valid=0: hold state, shreg and cnt; gaps of any length are allowed.
- SHIFT, ser_valid=1 and frame_start=0:
  - Shift and increment cnt.
  - If this is bit index WIDTH-1, the word is complete: go to IDLE, or to PARITY if the macro is enabled.
- SHIFT, ser_valid=1 and frame_start=1:
  - Abort the partial frame and set frame_err.
  - Restart with this bit as bit 0: cnt=1, stay in SHIFT.
- Word completion, on the cycle the last bit is accepted (shift result {ser_in, shreg[WIDTH-1:1]}):
  - Free buffer (out_valid=0, or out_valid=1 and out_ready=1 this cycle): load out_word, out_valid=1 on the next cycle. Latency from the last bit sample to out_valid is 1 clk.
  - Full buffer (out_valid=1 and out_ready=0): the word is dropped, overrun is set, and out_word/out_valid are unchanged.
- Handshake: a transfer occurs when out_valid&out_ready at posedge. out_valid falls after the transfer unless a new word is loaded in the same cycle; out_valid then stays 1 with the new out_word. out_word is stable while out_valid=1 and out_ready=0.
- Sticky flags:
  - Set conditions take priority over clear_err in the same cycle.
  - Flags clear only on reset or on clear_err with no set event that cycle.
- busy = (state != IDLE).
- out_ready is ignored while out_valid=0.

Optional Feature:
PARITY_CHECK_EN
- Defined:
  - After the WIDTH-th data bit, the FSM enters PARITY and waits for one more ser_valid bit (even parity: XOR of the data bits and the parity bit must equal 0).
  - Match: the word completes under the completion rules above, evaluated on the parity-bit cycle.
  - Mismatch: the word is discarded and parity_err is set.
  - frame_start=1 on the parity bit: treated as an abort, as in SHIFT.
  - Return to IDLE after the parity bit.
- Undefined: no PARITY state; the word completes on the WIDTH-th bit; parity_err is constant 0.

Test Plan:
- Reset: assert reset for 2 clk mid-frame, after 2 bits of a frame → out_valid=0, busy=0, all flags 0, out_word=0; the next full frame is received correctly.
- Basic receive: WIDTH=4, out_ready=1, send 1,1,0,1 with frame_start on the first bit → out_valid pulses 1 clk, one cycle after the last bit, with out_word=4'hB.
- Gaps and ignore: ser_valid=1 with frame_start=0 in IDLE (3 bits), then frame 0,0,1,0 with 2-cycle gaps between bits → no output from the stray bits; out_word=4'h4.
- Backpressure/overrun: out_ready=0, send frames 4'hA then 4'h5 → out_word stays 4'hA, overrun=1. Then out_ready=1 → 4'hA is transferred. Then clear_err → overrun=0.
- Simultaneous: out_valid=1 holding 4'h3, with out_ready=1 on the same cycle the last bit of 4'hC arrives → out_valid stays 1, out_word=4'hC, overrun=0.
- Abort/parity: frame_start re-asserted on bit 2 → frame_err=1, and the restarted frame 4'h9 is received. With PARITY_CHECK_EN: data 4'h7 followed by parity bit 0 → parity_err=1 and no out_valid; parity bit 1 → out_word=4'h7.
